// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and constants for the AXI4-Lite master
// Purpose: FSM state encoding and AXI response codes used by axil_master
//          and by its verification bench.
// Ports:   none (package).
package axil_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      READ  = 3'd3,
      RDATA = 3'd4,
      RSP   = 3'd5
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite master with command/response ports
// Purpose: accepts one read or write command at a time, runs it on the
//          AXI4-Lite bus and returns the completion on the response port.
// Ports:
//   m_axi_aclk, m_axi_areset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/wdata/wstrb      command payload (wdata/wstrb ignored for reads)
//   rsp_valid/rsp_ready             response handshake
//   rsp_write/rdata/resp            completion type, read data, BRESP/RRESP
//   m_axi_aw*/w*/b*/ar*/r*          AXI4-Lite master channels
// Every output is driven straight from a flop.
module axil_master
   import axil_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 4
) (
   input  logic                          m_axi_aclk,
   input  logic                          m_axi_areset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                   cmd_wdata,
   input  logic [3:0]                    cmd_wstrb,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_write,
   output logic [31:0]                   rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [31:0]                   m_axi_wdata,
   output logic [3:0]                    m_axi_wstrb,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [31:0]                   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp
);

   state_t                          state_q, state_d;
   logic                            cmd_ready_d;
   logic                            awvalid_d, wvalid_d, arvalid_d;
   logic                            bready_d, rready_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
   logic [31:0]                     wdata_d;
   logic [3:0]                      wstrb_d;
   logic                            rsp_valid_d, rsp_write_d;
   logic [31:0]                     rsp_rdata_d;
   logic [1:0]                      rsp_resp_d;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   // Next-state and next-output logic. Each output flop's next value is
   // computed here so that the flops hold exactly what the bus sees next cycle.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = 1'b0;
      awvalid_d   = m_axi_awvalid;
      wvalid_d    = m_axi_wvalid;
      arvalid_d   = m_axi_arvalid;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      awaddr_d    = m_axi_awaddr;
      araddr_d    = m_axi_araddr;
      wdata_d     = m_axi_wdata;
      wstrb_d     = m_axi_wstrb;
      rsp_valid_d = rsp_valid;
      rsp_write_d = rsp_write;
      rsp_rdata_d = rsp_rdata;
      rsp_resp_d  = rsp_resp;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_write) begin
                  state_d   = WRITE;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
               end else begin
                  state_d   = READ;
                  arvalid_d = 1'b1;
                  araddr_d  = cmd_addr;
               end
            end else begin
               cmd_ready_d = 1'b1;
            end
         end

         WRITE: begin
            // AW and W complete independently; a channel whose valid is
            // already low has finished its handshake.
            if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WRESP;
               bready_d = 1'b1;
            end
         end

         WRESP: begin
            bready_d = 1'b1;
            if (m_axi_bvalid && m_axi_bready) begin
               bready_d    = 1'b0;
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = 32'h0;
               rsp_resp_d  = m_axi_bresp;
            end
         end

         READ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RDATA;
               rready_d  = 1'b1;
            end
         end

         RDATA: begin
            rready_d = 1'b1;
            if (m_axi_rvalid && m_axi_rready) begin
               rready_d    = 1'b0;
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = m_axi_rdata;
               rsp_resp_d  = m_axi_rresp;
            end
         end

         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               cmd_ready_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q       <= IDLE;
         cmd_ready     <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_araddr  <= '0;
         m_axi_wdata   <= 32'h0;
         m_axi_wstrb   <= 4'h0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= 32'h0;
         rsp_resp      <= OKAY;
      end else begin
         state_q       <= state_d;
         cmd_ready     <= cmd_ready_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_bready  <= bready_d;
         m_axi_rready  <= rready_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_araddr  <= araddr_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         rsp_valid     <= rsp_valid_d;
         rsp_write     <= rsp_write_d;
         rsp_rdata     <= rsp_rdata_d;
         rsp_resp      <= rsp_resp_d;
      end
   end

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - scoreboard bench for axil_master with a delay-configurable slave
module tb_axil_master;
   import axil_pkg::*;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   axil_master #(.C_M_AXI_ADDR_WIDTH(AW)) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   logic [1:0]  b_resp_cfg = OKAY, r_resp_cfg = OKAY;
   logic [31:0] r_data_cfg = 32'h0;
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_seen, w_seen;
   int          cyc = 0;
   int          b_hs = 0;
   int          rsp_cnt = 0;

   assign awready = awvalid && (aw_cnt >= aw_delay);
   assign wready  = wvalid  && (w_cnt  >= w_delay);
   assign arready = arvalid && (ar_cnt >= ar_delay);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bvalid && bready) b_hs <= b_hs + 1;
      if (rst) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00;
         rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (bvalid && bready) bvalid <= 1'b0;
         if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
            bvalid  <= 1'b1;
            bresp   <= b_resp_cfg;
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
         end else begin
            if (awvalid && awready) aw_seen <= 1'b1;
            if (wvalid && wready)   w_seen  <= 1'b1;
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= r_data_cfg;
            rresp  <= r_resp_cfg;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      logic [3:0]    strb;
      logic [31:0]   data;
      logic [1:0]    resp;
      int            cyc;
   } exp_t;
   exp_t q[$];

   logic busy = 1'b0;
   logic ready_next = 1'b0;
   logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
   logic [AW-1:0] p_awaddr, p_araddr;
   logic [35:0]   p_w;
   logic [34:0]   p_rsp;

   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0; ready_next = 1'b0;
         p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
      end else begin
         if (ready_next) begin
            chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
            ready_next = 1'b0;
         end
         if (busy) chk("cmd_ready_busy", cmd_ready, 1'b0);

         if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
         if (p_wv && !p_wr)   chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, p_w});
         if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
         if (p_rv && !p_rr)   chk("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, p_rsp});

         if (rsp_valid)
            chk("quiet_in_rsp", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, awprot, arprot},
                12'h000);

         if (q.size() != 0) begin
            if (awvalid && awready) chk("awaddr", awaddr, q[0].addr);
            if (wvalid && wready)   chk("wdata_wstrb", {wdata, wstrb}, {q[0].wd, q[0].strb});
            if (arvalid && arready) chk("araddr", araddr, q[0].addr);
         end

         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (q.size() == 0) begin
               chk("unexpected_rsp", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_payload", {rsp_write, rsp_rdata, rsp_resp}, {e.wr, e.data, e.resp});
               if (e.cyc >= 0) chk("rsp_latency", cyc, e.cyc);
            end
            busy = 1'b0;
            ready_next = 1'b1;
         end

         p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
         p_wv = wvalid; p_wr = wready; p_w = {wdata, wstrb};
         p_arv = arvalid; p_arr = arready; p_araddr = araddr;
         p_rv = rsp_valid; p_rr = rsp_ready; p_rsp = {rsp_write, rsp_rdata, rsp_resp};
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp, input bit timed, input bit push);
      exp_t e;
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_accept_timeout", 1'b0, 1'b1);
         cmd_valid = 1'b0;
         return;
      end
      e.wr = wr; e.addr = addr; e.wd = wd; e.strb = strb;
      e.data = exp_data; e.resp = exp_resp;
      e.cyc = timed ? cyc + 3 : -1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      busy = 1'b1;
   endtask

   int n_ar, n_wonly;

   task automatic wait_idle();
      int n;
      n = 0; n_ar = 0; n_wonly = 0;
      do begin
         @(negedge clk);
         if (arvalid) n_ar++;
         if (!awvalid && wvalid) n_wonly++;
         n++;
      end while (q.size() != 0 && n < 100);
      if (q.size() != 0) begin
         chk("rsp_timeout", 1'b0, 1'b1);
         q.delete();
      end
   endtask

   initial begin
      int b0, r0, n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write,
           awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp},
          '0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset", cmd_ready, 1'b1);

      // Write with AW accepted two cycles before W
      aw_delay = 1; w_delay = 3; b_resp_cfg = OKAY;
      b0 = b_hs;
      issue(1'b1, 4'h4, 32'h0000_00FF, 4'hF, 32'h0, OKAY, 1'b0, 1'b1);
      wait_idle();
      chk("w_only_cycles", n_wonly, 2);
      chk("b_handshakes", b_hs - b0, 1);

      // Read with arready delayed 3 cycles
      aw_delay = 0; w_delay = 0; ar_delay = 3;
      r_data_cfg = 32'h1234_5678; r_resp_cfg = OKAY;
      issue(1'b0, 4'h8, 32'h0, 4'h0, 32'h1234_5678, OKAY, 1'b0, 1'b1);
      wait_idle();
      chk("arvalid_cycles", n_ar, 4);

      // Zero-wait back-to-back write then read
      ar_delay = 0;
      issue(1'b1, 4'hC, 32'hA5A5_0001, 4'h3, 32'h0, OKAY, 1'b1, 1'b1);
      r_data_cfg = 32'hCAFE_F00D;
      issue(1'b0, 4'h0, 32'h0, 4'h0, 32'hCAFE_F00D, OKAY, 1'b1, 1'b1);
      wait_idle();

      // Response back-pressure for 5 cycles, EXOKAY pass-through
      rsp_ready = 1'b0;
      r_data_cfg = 32'h0BAD_BEEF; r_resp_cfg = EXOKAY;
      issue(1'b0, 4'h4, 32'h0, 4'h0, 32'h0BAD_BEEF, EXOKAY, 1'b0, 1'b1);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rsp_held_valid", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'h0BAD_BEEF, EXOKAY});
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_idle();

      // Error responses pass through unmodified
      b_resp_cfg = SLVERR;
      issue(1'b1, 4'h8, 32'h1111_2222, 4'h5, 32'h0, SLVERR, 1'b1, 1'b1);
      wait_idle();
      r_data_cfg = 32'hDEAD_0000; r_resp_cfg = DECERR;
      issue(1'b0, 4'hF, 32'h0, 4'h0, 32'hDEAD_0000, DECERR, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);
      chk("idle_after_err", cmd_ready, 1'b1);

      // Reset while in WRESP with bvalid pending
      b_resp_cfg = OKAY;
      r0 = rsp_cnt;
      issue(1'b1, 4'h2, 32'h3333_4444, 4'hF, 32'h0, OKAY, 1'b0, 1'b0);
      n = 0;
      while (!(bvalid && bready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bvalid_pending", {bvalid, bready}, 2'b11);
      rst = 1'b1;
      busy = 1'b0;
      @(negedge clk);
      chk("valids_after_reset", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 7'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset2", {cmd_ready, rsp_valid}, 2'b10);
      repeat (3) @(negedge clk);
      chk("no_rsp_after_abort", rsp_cnt - r0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1);
   end

endmodule
